interleaver_ctrl: RTL and testbench
===================================

INTERLEAVER_CTRL -- requirements
Module: interleaver_ctrl

Interface
REQ-001 SHALL have parameter NCBPS, default 192, meaning coded bits per interleaver block.
REQ-002 SHALL have parameter NCPC, default 2, meaning coded bits per carrier (QPSK).
REQ-003 SHALL have parameter D, default 16, meaning interleaver column depth.
REQ-004 SHALL have port clk  input  1  meaning the single clock; all logic on its rising edge.
REQ-005 SHALL have port resetN  input  1  meaning reset, synchronous and active-low.
REQ-006 SHALL have port valid_fec  input  1  meaning the FEC coded bit is valid.
REQ-007 SHALL have port sof_fec  input  1  meaning the FEC bit is the first of a block; qualified by valid_fec.
REQ-008 SHALL have port ready_interleaver  output  1  meaning the controller can accept a FEC bit.
REQ-009 SHALL have port wr_en  output  1  meaning write the FEC bit into the buffer.
REQ-010 SHALL have port wr_bank  output  1  meaning the ping-pong bank being written.
REQ-011 SHALL have port wr_addr  output  $clog2(NCBPS)  meaning the permuted bit index j within the bank.
REQ-012 SHALL have port ready_mod  input  1  meaning the modulator accepts a block.
REQ-013 SHALL have port valid_interleaver  output  1  meaning the block in rd_bank is complete.
REQ-014 SHALL have port rd_bank  output  1  meaning the bank presented to the modulator.
REQ-015 SHALL have port sof_err  output  1  meaning a one-cycle pulse when a block is aborted.
REQ-016 SHALL have port blk_count  output  16  meaning the number of blocks handed to the modulator, wrapping.

Function
REQ-017 SHALL keep input index k (0..NCBPS-1), wr_bank, rd_bank, and bank_full[1:0].
REQ-018 SHALL drive ready_interleaver = !bank_full[wr_bank], combinationally.
REQ-019 SHALL drive wr_en = valid_fec & ready_interleaver; an accepted bit is written the same cycle.
REQ-020 SHALL compute wr_addr combinationally from the effective k, for k in 0..NCBPS-1:
- m = (NCBPS/D)*(k mod D) + floor(k/D)
- j = s*floor(m/s) + ((m + NCBPS - floor(D*m/NCBPS)) mod s), with s = NCPC/2
REQ-021 SHALL evaluate all intermediate products at a width of at least $clog2(NCBPS*D)+1 bits, so no product truncates.
REQ-022 SHALL use effective k = 0 when sof_fec & valid_fec; otherwise effective k = k.
REQ-023 SHALL, on an accepted bit with effective k < NCBPS-1, set k <= effective k + 1.
REQ-024 SHALL, on an accepted bit with effective k = NCBPS-1:
- set k <= 0
- set bank_full[wr_bank] <= 1
- toggle wr_bank
REQ-025 SHALL, when sof_fec & valid_fec arrive while k != 0, pulse sof_err high for exactly one cycle.
REQ-026 SHALL, in the REQ-025 case, discard the partial block: the bank and wr_bank are unchanged and writing restarts at index 0.
REQ-027 SHALL drive valid_interleaver = bank_full[rd_bank]; it asserts the cycle after the last bit is accepted (latency 1).
REQ-028 SHALL, on valid_interleaver & ready_mod:
- clear bank_full[rd_bank]
- toggle rd_bank
- increment blk_count modulo 2^16
REQ-029 SHALL apply a simultaneous fill (REQ-024) and drain (REQ-028) in the same cycle, both taking effect.
REQ-030 SHALL deassert ready_interleaver with k held when both banks are full; no bit is lost or overwritten.
REQ-031 SHALL hold valid_interleaver and rd_bank stable until ready_mod is asserted.
REQ-032 SHALL ignore sof_fec when valid_fec is low.

Reset
REQ-033 SHALL, on resetN low at a clock edge, set k=0, wr_bank=0, rd_bank=0, bank_full=00, sof_err=0, blk_count=0.
REQ-034 SHALL, with the REQ-033 state, give outputs ready_interleaver=1, valid_interleaver=0, wr_en=0 (when valid_fec=0).
REQ-035 SHALL, on reset mid-block or mid-handshake, abandon all buffered blocks with no sof_err pulse.

Structure
REQ-036 SHALL place NCBPS, NCPC, D default constants and a width localparam for k in shared package wimax_pkg.
REQ-037 SHALL implement the REQ-020 permutation in one combinational sub-module interleave_addr (k in, j out), instantiated once.

Verification
REQ-038 SHALL test reset then one block: 192 valid bits with sof_fec on bit 0 ->
- wr_addr sequence starts 0, 12, 24; k=16 gives 1; k=191 gives 191
- valid_interleaver=1 one cycle after the last bit; rd_bank=0
REQ-039 SHALL test ready_mod held low for 3 blocks ->
- blocks 1 and 2 fill banks 0 and 1
- ready_interleaver=0 from then on, and the 385th bit is not accepted
- after one ready_mod pulse, ready_interleaver=1 and blk_count=1
REQ-040 SHALL test sof_fec at bit 100 of a block -> sof_err pulses once, the next wr_addr=0, and bank_full is unchanged.
REQ-041 SHALL test the last bit of bank 1 accepted in the same cycle as a drain of bank 0 -> bank_full=10, wr_bank=0, rd_bank=1.
REQ-042 SHALL test resetN low at k=57 with bank 0 full -> all state as REQ-033 the next cycle, and valid_interleaver=0.
REQ-043 SHALL test 65537 block drains -> blk_count wraps to 1.

Source files
------------

// File: rtl/wimax_pkg.sv
// wimax_pkg: shared default interleaver geometry and index width
package wimax_pkg;
   localparam int NCBPS_DEF = 192;
   localparam int NCPC_DEF = 2;
   localparam int D_DEF = 16;
   localparam int KW_DEF = $clog2(NCBPS_DEF);
endpackage

// File: rtl/interleave_addr.sv
// interleave_addr: two-step block interleaver permutation, input index k to buffer index j
module interleave_addr
   import wimax_pkg::*;
#(
   parameter int NCBPS = NCBPS_DEF,
   parameter int NCPC = NCPC_DEF,
   parameter int D = D_DEF,
   localparam int KW = $clog2(NCBPS)
) (
   input  logic [KW-1:0] k,
   output logic [KW-1:0] j
);
   // wide enough that D*m never truncates
   localparam int PW = $clog2(NCBPS * D) + 1;
   localparam int S = (NCPC / 2 < 1) ? 1 : NCPC / 2;
   localparam logic [PW-1:0] N = PW'(NCBPS);
   localparam logic [PW-1:0] DD = PW'(D);
   localparam logic [PW-1:0] R = PW'(NCBPS / D);
   localparam logic [PW-1:0] SS = PW'(S);
   logic [PW-1:0] kk, m;
   assign kk = PW'(k);
   assign m = R * (kk % DD) + kk / DD;
   assign j = KW'(SS * (m / SS) + ((m + N - (DD * m) / N) % SS));
endmodule

// File: rtl/interleaver_ctrl.sv
// interleaver_ctrl: ping-pong bank controller between the FEC stream and the modulator
module interleaver_ctrl
   import wimax_pkg::*;
#(
   parameter int NCBPS = NCBPS_DEF,
   parameter int NCPC = NCPC_DEF,
   parameter int D = D_DEF,
   localparam int KW = $clog2(NCBPS)
) (
   input  logic          clk,
   input  logic          resetN,
   input  logic          valid_fec,
   input  logic          sof_fec,
   output logic          ready_interleaver,
   output logic          wr_en,
   output logic          wr_bank,
   output logic [KW-1:0] wr_addr,
   input  logic          ready_mod,
   output logic          valid_interleaver,
   output logic          rd_bank,
   output logic          sof_err,
   output logic [15:0]   blk_count
);
   localparam logic [KW-1:0] LAST = KW'(NCBPS - 1);
   logic [KW-1:0] k, k_eff;
   logic [1:0] bank_full, bank_full_nxt;
   logic sof, fill, drain;
   assign sof = valid_fec & sof_fec;
   assign k_eff = sof ? '0 : k;
   assign ready_interleaver = !bank_full[wr_bank];
   assign wr_en = valid_fec & ready_interleaver;
   assign valid_interleaver = bank_full[rd_bank];
   assign fill = wr_en && k_eff == LAST;
   assign drain = valid_interleaver & ready_mod;
   // fill and drain never target the same bank, so both updates can land together
   always_comb begin
      bank_full_nxt = bank_full;
      if (drain) bank_full_nxt[rd_bank] = 1'b0;
      if (fill) bank_full_nxt[wr_bank] = 1'b1;
   end
   interleave_addr #(.NCBPS(NCBPS), .NCPC(NCPC), .D(D)) u_addr (.k(k_eff), .j(wr_addr));
   always_ff @(posedge clk)
      if (!resetN) begin
         k <= '0;
         wr_bank <= 1'b0;
         rd_bank <= 1'b0;
         bank_full <= 2'b00;
         sof_err <= 1'b0;
         blk_count <= '0;
      end else begin
         sof_err <= sof && k != '0;
         bank_full <= bank_full_nxt;
         if (wr_en) k <= fill ? '0 : k_eff + 1'b1;
         if (fill) wr_bank <= ~wr_bank;
         if (drain) begin
            rd_bank <= ~rd_bank;
            blk_count <= blk_count + 1'b1;
         end
      end
endmodule

// File: tb/tb_interleaver_ctrl.sv
// tb_interleaver_ctrl: directed corner cases plus random traffic against a block-count model
module tb_interleaver_ctrl;
   localparam int N = 192;
   localparam int DP = 16;
   localparam int NC = 2;
   logic clk = 0, resetN, valid_fec, sof_fec, ready_mod;
   logic ready_interleaver, wr_en, wr_bank, valid_interleaver, rd_bank, sof_err;
   logic [7:0] wr_addr;
   logic [15:0] blk_count;
   typedef struct {int k; int j;} vec_t;
   typedef struct packed {logic rdy, we, vld, rdb, wrb, err; logic [7:0] addr; logic [15:0] blk;} obs_t;
   vec_t tbl[7];
   obs_t obs;
   int nchk = 0, npass = 0;
   int mk, nfill, ndrain, mblk;
   bit merr;
   always #5 clk = ~clk;
   interleaver_ctrl dut (
      .clk(clk), .resetN(resetN), .valid_fec(valid_fec), .sof_fec(sof_fec),
      .ready_interleaver(ready_interleaver), .wr_en(wr_en), .wr_bank(wr_bank),
      .wr_addr(wr_addr), .ready_mod(ready_mod), .valid_interleaver(valid_interleaver),
      .rd_bank(rd_bank), .sof_err(sof_err), .blk_count(blk_count)
   );
   function automatic int ref_j(int k);
      int m, s;
      m = (N / DP) * (k % DP) + k / DP;
      s = (NC / 2 < 1) ? 1 : NC / 2;
      return s * (m / s) + ((m + N - (DP * m) / N) % s);
   endfunction
   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      nchk++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask
   // banks are modelled as counts of filled and drained blocks, not as flags
   task automatic step(input bit v, input bit s, input bit rm);
      int keff;
      bit rdy, we, vld;
      @(negedge clk);
      valid_fec = v; sof_fec = s; ready_mod = rm;
      #1;
      keff = (v && s) ? 0 : mk;
      rdy = (nfill - ndrain) < 2;
      we = v && rdy;
      vld = nfill > ndrain;
      obs = {ready_interleaver, wr_en, valid_interleaver, rd_bank, wr_bank, sof_err, wr_addr, blk_count};
      chk("ready", ready_interleaver, rdy);
      chk("wr_en", wr_en, we);
      if (we) chk("wr_addr", wr_addr, ref_j(keff));
      chk("valid_int", valid_interleaver, vld);
      chk("rd_bank", rd_bank, ndrain % 2);
      chk("wr_bank", wr_bank, nfill % 2);
      chk("sof_err", sof_err, merr);
      chk("blk_count", blk_count, mblk % 65536);
      @(posedge clk);
      merr = v && s && mk != 0;
      if (we) begin
         if (keff == N - 1) begin mk = 0; nfill++; end
         else mk = keff + 1;
      end
      if (vld && rm) begin ndrain++; mblk++; end
   endtask
   task automatic feed(int n, bit sof_first, bit rm);
      for (int i = 0; i < n; i++) step(1, sof_first && i == 0, rm);
   endtask
   task automatic do_reset();
      @(negedge clk);
      resetN = 0; valid_fec = 0; sof_fec = 0; ready_mod = 0;
      @(posedge clk);
      mk = 0; nfill = 0; ndrain = 0; mblk = 0; merr = 0;
      @(negedge clk);
      #1;
      chk("rst_ready", ready_interleaver, 1);
      chk("rst_valid", valid_interleaver, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_rd_bank", rd_bank, 0);
      chk("rst_wr_bank", wr_bank, 0);
      chk("rst_sof_err", sof_err, 0);
      chk("rst_blk", blk_count, 0);
      resetN = 1;
   endtask
   initial begin
      tbl = '{'{0, 0}, '{1, 12}, '{2, 24}, '{15, 180}, '{16, 1}, '{17, 13}, '{191, 191}};
      resetN = 0; valid_fec = 0; sof_fec = 0; ready_mod = 0;
      do_reset();
      step(0, 0, 0);
      for (int i = 0; i < N; i++) begin
         step(1, i == 0, 0);
         foreach (tbl[t]) if (tbl[t].k == i) chk("tbl_addr", obs.addr, tbl[t].j);
      end
      step(0, 0, 0);
      chk("blk1_valid", obs.vld, 1);
      chk("blk1_rd_bank", obs.rdb, 0);
      feed(N, 1, 0);
      step(0, 0, 0);
      chk("both_full_ready", obs.rdy, 0);
      step(1, 1, 0);
      chk("bit385_wr_en", obs.we, 0);
      step(1, 0, 0);
      chk("held_wr_en", obs.we, 0);
      step(0, 0, 1);
      step(0, 0, 0);
      chk("drain_ready", obs.rdy, 1);
      chk("drain_blk", obs.blk, 1);
      step(0, 0, 1);
      feed(N, 1, 0);
      feed(N - 1, 1, 0);
      step(1, 0, 1);
      step(0, 0, 0);
      chk("simul_valid", obs.vld, 1);
      chk("simul_rd_bank", obs.rdb, 1);
      chk("simul_wr_bank", obs.wrb, 0);
      chk("simul_ready", obs.rdy, 1);
      step(0, 0, 1);
      feed(100, 1, 0);
      step(1, 1, 0);
      chk("sof_mid_addr", obs.addr, 0);
      chk("sof_mid_we", obs.we, 1);
      step(1, 0, 0);
      chk("sof_err_pulse", obs.err, 1);
      chk("sof_next_addr", obs.addr, 12);
      chk("sof_bank_valid", obs.vld, 0);
      chk("sof_bank_wr", obs.wrb, 0);
      step(0, 0, 0);
      chk("sof_err_once", obs.err, 0);
      feed(N - 2, 0, 0);
      feed(57, 1, 0);
      do_reset();
      step(1, 0, 0);
      chk("post_rst_addr", obs.addr, 0);
      do_reset();
      @(negedge clk);
      force dut.blk_count = 16'hFFFF;
      #1 release dut.blk_count;
      mblk = 65535;
      feed(N, 1, 0);
      step(0, 0, 1);
      step(0, 0, 0);
      chk("wrap_zero", obs.blk, 0);
      feed(N, 1, 0);
      step(0, 0, 1);
      step(0, 0, 0);
      chk("wrap_one", obs.blk, 1);
      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 9) < 8, $urandom_range(0, 199) == 0 || (mk == 0 && $urandom_range(0, 1) == 1),
              $urandom_range(0, 3) == 0);
      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end
endmodule
